// File: rtl/sram_mem_bridge.sv
// Purpose : arbitrates the core's fetch and load/store SRAM-like ports onto one shared memory port.
// Latency : accept in cycle 0, mem_req from cycle 1, *_data_ok one cycle after mem_rvalid (cycle 3 best case).
// Backpressure: one transaction in flight; *_addr_ok only in IDLE, stallreq holds the core otherwise.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   inst_req/addr/addr_ok      fetch request side; inst_data_ok/inst_rdata fetch completion
//   data_req/wen/addr/wdata    load/store request side (wen==0 is a load); data_addr_ok accepts it
//   data_data_ok/data_rdata    load/store completion
//   mem_req/wen/addr/wdata     shared memory request, held stable until mem_gnt
//   mem_gnt/rvalid/rdata       memory grant and response (rvalid also closes writes)
//   stallreq                   hold request to the core's stall control
//   err                        sticky response-timeout flag
module sram_mem_bridge #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stallreq,
  output logic              err
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  // Completing on the cycle the counter would reach TIMEOUT gives exactly
  // TIMEOUT cycles in RESP before the error response.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_data_q;   // 1: load/store path owns the transaction
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              done;
  logic              timed_out;
  logic [DATA_W-1:0] resp_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    mem_req      = 1'b0;
    accept       = 1'b0;
    done         = 1'b0;
    timed_out    = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_req) begin
          data_addr_ok = 1'b1;
          accept       = 1'b1;
        end else if (inst_req) begin
          inst_addr_ok = 1'b1;
          accept       = 1'b1;
        end
        if (accept) state_d = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = RESP;
      end
      RESP: begin
        // A real response wins over a coincident timeout.
        if (mem_rvalid) begin
          done = 1'b1;
        end else if (cnt_q >= CNT_LAST) begin
          done      = 1'b1;
          timed_out = 1'b1;
        end
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stallreq = (state_q != IDLE) | (inst_req & ~inst_addr_ok) | (data_req & ~data_addr_ok);
  assign resp_dat = mem_rvalid ? mem_rdata : ERR_DATA;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_data_q <= 1'b0;
      mem_wen      <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cnt_q        <= '0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
      err          <= 1'b0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;

      // Latched request doubles as the memory-side request registers.
      if (accept) begin
        owner_data_q <= data_addr_ok;
        mem_addr     <= data_addr_ok ? data_addr  : inst_addr;
        mem_wen      <= data_addr_ok ? data_wen   : 4'b0000;
        mem_wdata    <= data_addr_ok ? data_wdata : '0;
      end

      if (state_q == REQ && mem_gnt) begin
        cnt_q <= '0;
      end else if (state_q == RESP && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (done) begin
        if (owner_data_q) begin
          data_rdata   <= resp_dat;
          data_data_ok <= 1'b1;
        end else begin
          inst_rdata   <= resp_dat;
          inst_data_ok <= 1'b1;
        end
        if (timed_out) err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sram_mem_bridge.md
Name: sram_mem_bridge

Overview:
- Sits directly downstream of the CPU core's inst/data SRAM-like ports.
- Arbitrates the fetch path and the load/store path onto a single shared memory port with a request/grant/response handshake.
- Returns read data and done pulses to the requesting path.
- Raises stallreq to the CTRL stall logic while the core must hold.
- One transaction is outstanding at a time. Data has priority over instruction.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- TIMEOUT, 255, maximum cycles spent in RESP before the bridge self-completes with an error.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- inst_req  in  1  fetch request.
- inst_addr  in  ADDR_W  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch data valid (one-cycle pulse).
- inst_rdata  out  DATA_W  fetched word.
- data_req  in  1  load/store request.
- data_wen  in  4  byte write enables; 0 means load.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_addr_ok  out  1  load/store request accepted this cycle.
- data_data_ok  out  1  load/store complete (one-cycle pulse).
- data_rdata  out  DATA_W  load data.
- mem_req  out  1  memory request valid.
- mem_wen  out  4  byte write enables to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_gnt  in  1  memory accepted mem_req this cycle.
- mem_rvalid  in  1  memory response valid; asserted for both reads and writes.
- mem_rdata  in  DATA_W  memory read data.
- stallreq  out  1  hold request to CTRL.
- err  out  1  sticky timeout flag.

Behaviour:

Reset (rst low, asynchronous):
- State goes to IDLE.
- Every registered output is 0: mem_req, mem_wen, mem_addr, mem_wdata, inst_data_ok, data_data_ok, inst_rdata, data_rdata, err.
- Latched owner, latched request and timeout counter are cleared.
- A transaction in flight when reset asserts is dropped. Nothing is replayed after reset.

FSM states: IDLE, REQ, RESP.

IDLE:
- Winner selection: data_req wins; otherwise inst_req wins.
- The winner's *_addr_ok is driven combinationally high in this same cycle. The loser's *_addr_ok stays 0.
- On the clock edge: latch owner, address, wen (inst: 4'b0000) and wdata (inst: 0); go to REQ.
- No request: stay in IDLE.

REQ:
- mem_req = 1, driven from the latched registers; these values are stable until grant.
- mem_gnt = 1: go to RESP and clear the timeout counter.
- mem_rvalid is ignored in this state.

RESP:
- mem_req = 0.
- mem_rvalid = 1:
  - Owner's *_rdata is registered from mem_rdata; for writes it is registered as well but is don't-care.
  - Owner's *_data_ok pulses high for exactly the next cycle.
  - State returns to IDLE on the same edge.
- Counter reaches TIMEOUT with no rvalid: behaves as if rvalid arrived with ERR_DATA, and err is set.
- err stays 1 until reset.

Latency:
- With gnt in the first REQ cycle and rvalid one cycle later, accept in cycle 0 gives data_ok in cycle 3.
- The next request can be accepted in cycle 3, because the FSM is in IDLE then.

Stall and output rules:
- stallreq = (state != IDLE) | (inst_req & ~inst_addr_ok) | (data_req & ~data_addr_ok).
- inst_data_ok and data_data_ok are never high in the same cycle.
- *_addr_ok is never high outside IDLE.
- *_rdata holds its last value between pulses.
- mem_gnt and mem_rvalid arriving while in IDLE are ignored.

Timeout counter:
- Width is clog2(TIMEOUT+1).
- Saturating; it never wraps.

Test Plan:
- Load: data_req=1, wen=0, addr=0x0000_0100; mem grants in the first REQ cycle and returns rvalid=1, rdata=0x1234_5678 the next cycle. Required: data_addr_ok in cycle 0, mem_req only in cycle 1, data_data_ok pulse in cycle 3 with data_rdata=0x1234_5678, stallreq high in cycles 1–2.
- Collision: inst_req and data_req both high in IDLE (inst addr 0xBFC0_0000, data addr 0x10). Required: data served first and inst_addr_ok=0 that cycle; inst accepted on the next IDLE cycle; memory sees two requests in order data then inst.
- Store with delayed grant: wen=4'b0011, wdata=0xAABB_CCDD; mem_gnt withheld 4 cycles. Required: mem_req held with mem_wen=0011 and constant addr/wdata for 5 cycles; data_data_ok pulses once after rvalid.
- Timeout: grant given, rvalid never asserted, TIMEOUT=8. Required: after 8 RESP cycles, owner's data_ok pulses with rdata=0xDEAD_BEEF; err=1 and stays 1 across later normal transactions.
- Reset mid-operation: rst driven low while in RESP. Required: outputs go to 0 immediately, without waiting for a clock edge. After release, a late mem_rvalid produces no data_ok, and a fresh inst fetch completes normally.
